// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: accepts one load/store
// at a time, stalls the pipeline while it is in flight, and pulses done/valid on completion.
module dmem_responder #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_d_cen,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_stall,
  output logic              o_d_valid_data,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, complete;
  logic              wen_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-offset and upper address bits do not select a word; the index wraps.
  logic unused_addr;
  assign unused_addr = ^i_d_addr;

  // State and countdown register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: requests are only looked at in IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_d_cen) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture at acceptance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wen_q   <= i_d_wen;
      idx_q   <= i_d_addr[IDX_W+2:3];
      wdata_q <= i_d_wdata;
    end
  end

  // Handshake outputs; stall mirrors BUSY one-for-one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_d_stall      <= 1'b0;
      o_d_done       <= 1'b0;
      o_d_valid_data <= 1'b0;
    end else begin
      o_d_stall      <= (state_d == BUSY);
      o_d_done       <= complete;
      o_d_valid_data <= complete & ~wen_q;
    end
  end

  // Storage and load data; rdata only moves on load completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      o_d_rdata <= '0;
    end else if (complete) begin
      if (wen_q) mem_q[idx_q] <= wdata_q;
      else       o_d_rdata    <= mem_q[idx_q];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_dmem_responder;

  typedef struct packed {
    logic        is_load;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       cen, wen, stall, valid, done;
  logic [1:0][63:0] addr, wdata, rdata;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt [2];

  dmem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .LATENCY(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_cen(cen[0]), .i_d_wen(wen[0]),
    .i_d_addr(addr[0]), .i_d_wdata(wdata[0]), .o_d_stall(stall[0]),
    .o_d_valid_data(valid[0]), .o_d_rdata(rdata[0]), .o_d_done(done[0])
  );

  dmem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(16), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_cen(cen[1]), .i_d_wen(wen[1]),
    .i_d_addr(addr[1]), .i_d_wdata(wdata[1]), .o_d_stall(stall[1]),
    .o_d_valid_data(valid[1]), .o_d_rdata(rdata[1]), .o_d_done(done[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic is_load, input logic [63:0] data);
    exp_t e;
    e.is_load = is_load;
    e.data    = data;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every done pulse consumes one expected response
  always @(negedge clk) begin : monitor
    exp_t e;
    logic have;
    for (int d = 0; d < 2; d++) begin
      if (valid[d]) chk("valid_implies_done", 64'(done[d]), 64'(1));
      if (done[d]) begin
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut%0d: got done=1, expected no response (t=%0t)", d, $time);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          done_cnt[d]++;
          chk("valid_data", 64'(valid[d]), 64'(e.is_load));
          if (e.is_load) chk("rdata", rdata[d], e.data);
        end
      end
    end
  end

  // Issue one request from an IDLE negedge; returns at the IDLE negedge after RESP
  task automatic issue(input int d, input logic w, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input int lat);
    int n;
    cen[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    push_exp(d, ~w, exp_rd);
    @(negedge clk);
    cen[d] = 1'b0;
    n = 0;
    while (stall[d] && n < 32) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(n), 64'(lat));
    @(negedge clk);
  endtask

  task automatic chk_zero(input int d);
    chk("rst_stall", 64'(stall[d]), 64'(0));
    chk("rst_valid", 64'(valid[d]), 64'(0));
    chk("rst_done",  64'(done[d]),  64'(0));
    chk("rst_rdata", rdata[d], 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, n;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst_n = 1'b0; cen = '0; wen = '0; addr = '0; wdata = '0;
    #1;
    chk_zero(0);
    chk_zero(1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load back
    issue(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'h0, 4);
    issue(0, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 4);

    // Index wrap and ignored byte offset
    issue(0, 1'b1, 64'h808, 64'h5, 64'h0, 4);
    issue(0, 1'b0, 64'h008, 64'h0, 64'h5, 4);
    issue(0, 1'b0, 64'h00F, 64'h0, 64'h5, 4);

    // Requests held during BUSY/RESP are ignored
    base = done_cnt[0];
    cen[0] = 1'b1; wen[0] = 1'b1; addr[0] = 64'h40; wdata[0] = 64'h1111;
    @(posedge clk);
    push_exp(0, 1'b0, 64'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      wen[0]   = (k % 2) == 1;
      addr[0]  = 64'(64'h40 + 8 * k);
      wdata[0] = 64'(64'hBAD0 + k);
      chk("busy_stall", 64'(stall[0]), 64'(k < 5));
    end
    @(negedge clk);
    wen[0] = 1'b0; addr[0] = 64'h40;
    @(posedge clk);
    push_exp(0, 1'b1, 64'h1111);
    @(negedge clk);
    cen[0] = 1'b0;
    n = 0;
    while (stall[0] && n < 32) begin n++; @(negedge clk); end
    chk("stall_cycles", 64'(n), 64'(4));
    @(negedge clk);
    chk("done_per_window", 64'(done_cnt[0] - base), 64'(2));
    issue(0, 1'b0, 64'h48, 64'h0, 64'h0, 4);
    issue(0, 1'b0, 64'h58, 64'h0, 64'h0, 4);

    // Stores leave rdata alone; idle hold
    issue(0, 1'b1, 64'h80, 64'hA, 64'h0, 4);
    issue(0, 1'b0, 64'h80, 64'h0, 64'hA, 4);
    issue(0, 1'b1, 64'h88, 64'h99, 64'h0, 4);
    chk("rdata_after_store", rdata[0], 64'hA);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_rdata", rdata[0], 64'hA);
      chk("idle_stall", 64'(stall[0]), 64'(0));
      chk("idle_done",  64'(done[0]),  64'(0));
      chk("idle_valid", 64'(valid[0]), 64'(0));
    end

    // Reset two cycles into a store
    cen[0] = 1'b1; wen[0] = 1'b1; addr[0] = 64'h20; wdata[0] = 64'h77;
    @(posedge clk);
    @(negedge clk);
    cen[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero(0);
    @(negedge clk);
    chk_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(0, 1'b0, 64'h20, 64'h0, 64'h0, 4);
    issue(0, 1'b0, 64'h80, 64'h0, 64'h0, 4);

    // LATENCY=1 instance
    issue(1, 1'b1, 64'h18, 64'h1_2345_6789, 64'h0, 1);
    issue(1, 1'b0, 64'h18, 64'h0, 64'h1_2345_6789, 1);
    issue(1, 1'b1, 64'h98, 64'hCAFE, 64'h0, 1);
    issue(1, 1'b0, 64'h18, 64'h0, 64'hCAFE, 1);

    repeat (3) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 256, storage depth in DATA_W words; power of two, at least 2.
REQ-004 SHALL have parameter LATENCY, default 4, request-to-response cycles; at least 1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; the ports are as follows.
REQ-006 i_clk  input  1  clock; all state changes on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_d_cen  input  1  request strobe from MEM stage.
REQ-009 i_d_wen  input  1  1 = store, 0 = load; sampled with i_d_cen.
REQ-010 i_d_addr  input  ADDR_W  byte address.
REQ-011 i_d_wdata  input  DATA_W  store data.
REQ-012 o_d_stall  output  1  pipeline stall while a request is in flight.
REQ-013 o_d_valid_data  output  1  one-cycle pulse: load data valid on o_d_rdata.
REQ-014 o_d_rdata  output  DATA_W  load data; holds its last value between loads.
REQ-015 o_d_done  output  1  one-cycle pulse on completion of any request, load or store.

Function
REQ-016 SHALL implement states IDLE, BUSY and RESP, plus a countdown counter of ceil(log2(LATENCY))+1 bits.
REQ-017 SHALL accept a request only at a rising edge where state is IDLE and i_d_cen=1 (edge E0).
- Latches i_d_wen, i_d_addr and i_d_wdata.
- Sets the counter to LATENCY-1.
- Moves to BUSY.
REQ-018 SHALL ignore i_d_cen and all request inputs while in BUSY or RESP; they have no effect on state, storage or outputs.
REQ-019 In BUSY, SHALL decrement the counter at each edge while it is nonzero; at the edge where it is 0 (edge E_LATENCY), SHALL move to RESP.
REQ-020 At edge E_LATENCY, a store SHALL write the latched wdata to word index addr[log2(DEPTH)+2:3].
REQ-021 At edge E_LATENCY, a load SHALL register storage[index] into o_d_rdata.
REQ-022 SHALL ignore address bits [2:0] and all bits above log2(DEPTH)+2; the index wraps modulo DEPTH.
REQ-023 SHALL assert o_d_done for exactly the one RESP cycle; o_d_valid_data is also high in that cycle only when the request was a load.
REQ-024 RESP SHALL last exactly one cycle and then go to IDLE; the earliest next acceptance is the edge leaving RESP +1, so back-to-back requests are spaced LATENCY+2 edges apart.
REQ-025 o_d_stall SHALL be 1 exactly when state is BUSY (registered, no combinational path from i_d_cen); it is 0 in RESP, so the pipeline advances in the same cycle the load data is valid.
REQ-026 With LATENCY=1: BUSY lasts one cycle, with o_d_stall high for one cycle, and RESP follows E1.
REQ-027 A load issued after a completed store to the same index SHALL return the stored data.
REQ-028 o_d_rdata SHALL change only at load completion; it is unchanged by stores.

Reset
REQ-029 On i_rst_n=0, immediately and independent of i_clk, SHALL set:
- state IDLE, counter 0;
- o_d_stall, o_d_valid_data and o_d_done to 0;
- o_d_rdata to 0;
- all storage words to 0.
REQ-030 Reset asserted mid-request SHALL abort it: no storage write, no done/valid pulse after release.
REQ-031 After release, the first rising edge with i_d_cen=1 SHALL be accepted.

Verification
REQ-032 Store/load: store addr 0x10, data 0xDEADBEEF_CAFEF00D; then load 0x10.
- Required: o_d_stall high for 4 cycles after each acceptance.
- Required: o_d_done pulses for both requests.
- Required: o_d_valid_data pulses only for the load, with o_d_rdata=0xDEADBEEF_CAFEF00D.
REQ-033 Ignored requests: hold i_d_cen=1 with changing addr/wen during BUSY and RESP.
- Required: exactly one request completes per LATENCY+2 edges.
- Required: the completed request's data and address are the values latched at acceptance.
REQ-034 Wrap: store 0x5 to addr 0x808 (DEPTH=256), load addr 0x008 -> o_d_rdata=0x5; load addr 0x00F -> o_d_rdata=0x5.
REQ-035 Reset mid-op: store 0x77 to addr 0x20, assert i_rst_n=0 two cycles after acceptance, release, load 0x20.
- Required: all outputs 0 during reset.
- Required: no pulse after release.
- Required: load returns 0.
REQ-036 LATENCY=1 build: load after store.
- Required: stall high one cycle per request.
- Required: valid in the cycle after E1.
- Required: data correct.
REQ-037 Idle hold: after a load returning 0xA, run 10 cycles with i_d_cen=0.
- Required: o_d_rdata stays 0xA.
- Required: o_d_stall, o_d_done and o_d_valid_data stay 0.
